sdcard_schedule_rom: RTL and testbench

Behavioural model of the SD card that stores the sprinkler controller's watering schedule. It holds a fixed ASCII text file of schedule lines and parses one line on request. Each parsed line is presented as three ASCII fields: zone, start time and stop time. It sits between the schedule/controller logic and the (modelled) storage medium, and replaces the real SD interface in simulation and FPGA bring-up.

---
 rtl/sdcard_schedule_rom.sv | 160 ++++++++++++++++
 tb/tb_sdcard_schedule_rom.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sdcard_schedule_rom.sv
// ============================================================================
// sdcard_schedule_rom
//   Behavioural SD-card model: fixed ASCII schedule file, one line parsed per
//   request into zone / start / stop ASCII fields.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdcard_schedule_rom #(
   parameter int LINES          = 12,
   parameter int BYTES_PER_LINE = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read_next_line,
   output logic        read_enable,
   output logic [15:0] zone,
   output logic [31:0] start_time,
   output logic [31:0] stop_time
);

   localparam int         ROM_BYTES = LINES * BYTES_PER_LINE;
   localparam logic [7:0] LAST_ADDR = 8'(ROM_BYTES - 1);
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FETCH = 1'b1
   } state_t;

   // File contents: line k is "ZZ,HH00,HH30\n" with ZZ = k+1 and HH = 6+k.
   function automatic logic [7:0] rom_init(input int a);
      int line;
      int pos;
      int zn;
      int hh;
      int ch;
      line = a / BYTES_PER_LINE;
      pos  = a % BYTES_PER_LINE;
      zn   = line + 1;
      hh   = 6 + line;
      case (pos)
         0:       ch = 48 + (zn / 10);
         1:       ch = 48 + (zn % 10);
         2, 7:    ch = 44;
         3, 8:    ch = 48 + (hh / 10);
         4, 9:    ch = 48 + (hh % 10);
         10:      ch = 51;
         12:      ch = 10;
         default: ch = 48;
      endcase
      return 8'(ch);
   endfunction

   logic [7:0] rom [0:ROM_BYTES-1];

   generate
      for (genvar i = 0; i < ROM_BYTES; i++) begin : g_rom
         assign rom[i] = rom_init(i);
      end
   endgenerate

   state_t      state_q,       state_d;
   logic [7:0]  addr_q,        addr_d;
   logic [1:0]  fidx_q,        fidx_d;
   logic [15:0] wzone_q,       wzone_d;
   logic [31:0] wstart_q,      wstart_d;
   logic [31:0] wstop_q,       wstop_d;
   logic        read_enable_q, read_enable_d;
   logic [15:0] zone_q,        zone_d;
   logic [31:0] start_time_q,  start_time_d;
   logic [31:0] stop_time_q,   stop_time_d;
   logic [7:0]  rom_byte;

   assign rom_byte = rom[addr_q];

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      fidx_d        = fidx_q;
      wzone_d       = wzone_q;
      wstart_d      = wstart_q;
      wstop_d       = wstop_q;
      read_enable_d = 1'b0;
      zone_d        = zone_q;
      start_time_d  = start_time_q;
      stop_time_d   = stop_time_q;

      case (state_q)
         S_IDLE: begin
            if (read_next_line) begin
               state_d  = S_FETCH;
               fidx_d   = 2'd0;
               wzone_d  = '0;
               wstart_d = '0;
               wstop_d  = '0;
            end
         end
         S_FETCH: begin
            addr_d = (addr_q == LAST_ADDR) ? 8'd0 : addr_q + 8'd1;
            if (rom_byte == CH_LF) begin
               zone_d        = wzone_q;
               start_time_d  = wstart_q;
               stop_time_d   = wstop_q;
               read_enable_d = 1'b1;
               fidx_d        = 2'd0;
               state_d       = S_IDLE;
            end else if (rom_byte == CH_COMMA) begin
               // Extra commas stay in the stop field rather than wrapping.
               if (fidx_q != 2'd2) begin
                  fidx_d = fidx_q + 2'd1;
               end
            end else if (rom_byte != CH_CR) begin
               case (fidx_q)
                  2'd0:    wzone_d  = {wzone_q[7:0], rom_byte};
                  2'd1:    wstart_d = {wstart_q[23:0], rom_byte};
                  default: wstop_d  = {wstop_q[23:0], rom_byte};
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         addr_q        <= 8'd0;
         fidx_q        <= 2'd0;
         wzone_q       <= '0;
         wstart_q      <= '0;
         wstop_q       <= '0;
         read_enable_q <= 1'b0;
         zone_q        <= '0;
         start_time_q  <= '0;
         stop_time_q   <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         fidx_q        <= fidx_d;
         wzone_q       <= wzone_d;
         wstart_q      <= wstart_d;
         wstop_q       <= wstop_d;
         read_enable_q <= read_enable_d;
         zone_q        <= zone_d;
         start_time_q  <= start_time_d;
         stop_time_q   <= stop_time_d;
      end
   end

   assign read_enable = read_enable_q;
   assign zone        = zone_q;
   assign start_time  = start_time_q;
   assign stop_time   = stop_time_q;

endmodule

`default_nettype wire

// File: tb/tb_sdcard_schedule_rom.sv
// ============================================================================
// tb_sdcard_schedule_rom
//   Directed self-checking bench for the schedule ROM line parser.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sdcard_schedule_rom;

   logic        clk;
   logic        rst_n;
   logic        read_next_line;
   logic        read_enable;
   logic [15:0] zone;
   logic [31:0] start_time;
   logic [31:0] stop_time;

   int n_tests = 0;
   int n_fail  = 0;

   sdcard_schedule_rom #(
      .LINES          (12),
      .BYTES_PER_LINE (13)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .read_next_line (read_next_line),
      .read_enable    (read_enable),
      .zone           (zone),
      .start_time     (start_time),
      .stop_time      (stop_time)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected ASCII fields of schedule line l.
   function automatic logic [15:0] exp_zone(input int l);
      return {8'(48 + (l + 1) / 10), 8'(48 + (l + 1) % 10)};
   endfunction
   function automatic logic [31:0] exp_start(input int l);
      return {8'(48 + (l + 6) / 10), 8'(48 + (l + 6) % 10), 8'h30, 8'h30};
   endfunction
   function automatic logic [31:0] exp_stop(input int l);
      return {8'(48 + (l + 6) / 10), 8'(48 + (l + 6) % 10), 8'h33, 8'h30};
   endfunction

   // Counts rising edges (sampled 1 time unit after) until a strobe or the bound.
   task automatic wait_strobe(input int max_cyc, output int cyc, output bit found);
      found = 1'b0;
      cyc   = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (read_enable === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_line(input string tag, input int l);
      check({tag, "_zone"},  {16'h0, zone}, {16'h0, exp_zone(l)});
      check({tag, "_start"}, start_time,    exp_start(l));
      check({tag, "_stop"},  stop_time,     exp_stop(l));
   endtask

   initial begin
      int  cyc;
      bit  found;
      int  strobes;

      rst_n          = 1'b0;
      read_next_line = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_re",    {31'h0, read_enable}, 32'h0);
      check("rst_zone",  {16'h0, zone},        32'h0);
      check("rst_start", start_time,           32'h0);
      check("rst_stop",  stop_time,            32'h0);
      rst_n = 1'b1;

      // Idle with no request.
      strobes = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (read_enable === 1'b1) strobes++;
      end
      check("idle_strobes", strobes,              32'd0);
      check("idle_zone",    {16'h0, zone},        32'h0);
      check("idle_start",   start_time,           32'h0);

      // First line: request sampled at E0, strobe on E13 (14th edge counted).
      read_next_line = 1'b1;
      wait_strobe(40, cyc, found);
      check("l0_found", {31'h0, found}, 32'h1);
      check("l0_lat",   cyc,            32'd14);
      check("l0_zone",  {16'h0, zone},  {16'h0, 16'h3031});
      check("l0_start", start_time,     32'h3036_3030);
      check("l0_stop",  stop_time,      32'h3036_3330);

      // Held request: lines 1..11 then wrap to line 0, 14 cycles apart.
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         check($sformatf("fall%0d", k), {31'h0, read_enable}, 32'h0);
         wait_strobe(40, cyc, found);
         check($sformatf("found%0d", k), {31'h0, found}, 32'h1);
         check($sformatf("gap%0d", k), cyc + 1, 32'd14);
         if (k == 10) begin
            check("l10_zone",  {16'h0, zone}, {16'h0, 16'h3131});
            check("l10_start", start_time,    32'h3136_3030);
            check("l10_stop",  stop_time,     32'h3136_3330);
         end else if (k == 12) begin
            check("wrap_zone",  {16'h0, zone}, {16'h0, 16'h3031});
            check("wrap_start", start_time,    32'h3036_3030);
         end else begin
            check_line($sformatf("l%0d", k), k);
         end
      end
      read_next_line = 1'b0;

      // No further strobes once the request drops.
      wait_strobe(30, cyc, found);
      check("drop_nostrobe", {31'h0, found}, 32'h0);
      check_line("hold", 0);

      // One-cycle pulse: exactly one strobe 13 edges after E0, line 1.
      read_next_line = 1'b1;
      @(posedge clk); #1;
      read_next_line = 1'b0;
      wait_strobe(40, cyc, found);
      check("pulse_found", {31'h0, found}, 32'h1);
      check("pulse_lat",   cyc,            32'd13);
      check_line("pulse", 1);
      wait_strobe(30, cyc, found);
      check("pulse_single", {31'h0, found}, 32'h0);

      // Line 2 via pulse, then reset during fetch of line 3.
      read_next_line = 1'b1;
      @(posedge clk); #1;
      read_next_line = 1'b0;
      wait_strobe(40, cyc, found);
      check("l2_found", {31'h0, found}, 32'h1);
      check_line("l2", 2);
      @(posedge clk); #1;
      read_next_line = 1'b1;
      @(posedge clk); #1;
      read_next_line = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_re",    {31'h0, read_enable}, 32'h0);
      check("arst_zone",  {16'h0, zone},        32'h0);
      check("arst_start", start_time,           32'h0);
      check("arst_stop",  stop_time,            32'h0);
      strobes = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (read_enable === 1'b1) strobes++;
      end
      check("arst_nostrobe", strobes, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // After reset the address restarts at line 0.
      read_next_line = 1'b1;
      @(posedge clk); #1;
      read_next_line = 1'b0;
      wait_strobe(40, cyc, found);
      check("post_found", {31'h0, found}, 32'h1);
      check("post_lat",   cyc,            32'd13);
      check("post_zone",  {16'h0, zone},  {16'h0, 16'h3031});
      check("post_start", start_time,     32'h3036_3030);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
